// File: rtl/pwm_pkg.sv
// pwm_pkg: shared encodings and reset fills for the pwm_multi block.
// Optional feature macro used by this slice: PWM_MULTI_DEADTIME_EN.
package pwm_pkg;

  // Alignment mode encoding as seen on mode_i and in the mode registers.
  localparam logic PWM_MODE_EDGE   = 1'b0;
  localparam logic PWM_MODE_CENTER = 1'b1;

  // Counter direction. Edge mode only ever uses DIR_UP.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  // Reset fills: the period resets to all ones, duties to all zeros,
  // so a freshly reset block produces a long, fully low waveform.
  localparam logic PWM_PERIOD_RST_FILL = 1'b1;
  localparam logic PWM_DUTY_RST_FILL   = 1'b0;

endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: dead-time insertion for one PWM channel.
// raw_i is the unregistered compare result. An output only rises once raw_i
// has held its level for more than DT consecutive enabled cycles, so the two
// outputs can never be high together and short pulses disappear.
module pwm_deadtime #(
  parameter int BW = 8,
  parameter int DT = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic raw_i,
  output logic pwm_o,
  output logic pwm_n_o
);

  // One extra bit so a DT of 2^BW-1 still has a reachable threshold.
  localparam int unsigned RUN_CAP_I = DT + 1;
  localparam logic [BW:0] RUN_CAP   = RUN_CAP_I[BW:0];

  logic        prev_raw;
  logic [BW:0] run_len;
  logic [BW:0] cur_len;

  // Length of the constant-level run of raw_i including this cycle, saturating at the threshold.
  always_comb begin
    cur_len = {{BW{1'b0}}, 1'b1};
    if (raw_i == prev_raw) begin
      if (run_len == RUN_CAP) begin
        cur_len = run_len;
      end else begin
        cur_len = run_len + 1'b1;
      end
    end
  end

  // Run tracking and registered outputs; disabling restarts the run so both outputs drop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_raw <= 1'b0;
      run_len  <= '0;
      pwm_o    <= 1'b0;
      pwm_n_o  <= 1'b0;
    end else if (!en_i) begin
      prev_raw <= 1'b0;
      run_len  <= '0;
      pwm_o    <= 1'b0;
      pwm_n_o  <= 1'b0;
    end else begin
      prev_raw <= raw_i;
      run_len  <= cur_len;
      pwm_o    <= raw_i && (cur_len >= RUN_CAP);
      pwm_n_o  <= !raw_i && (cur_len >= RUN_CAP);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with one shared period counter.
// Edge-aligned (period P+1) or center-aligned (period 2P) counting. Period,
// duty and mode are staged in shadow registers by load_i and copied into the
// active set only at a period boundary or while disabled, so a running
// waveform never sees a partial update.
// Optional feature macro: PWM_MULTI_DEADTIME_EN adds per-channel dead-time
// insertion and the complementary pwm_n_o outputs.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int BW = 8,
  parameter int CH = 4,
  parameter int DT = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic [BW-1:0]    period_i,
  input  logic [CH*BW-1:0] duty_i,
  input  logic             load_i,
  output logic             pending_o,
  output logic             sync_o,
  output logic [CH-1:0]    pwm_o
`ifdef PWM_MULTI_DEADTIME_EN
  ,
  output logic [CH-1:0]    pwm_n_o
`endif
);

  localparam logic [BW-1:0] P_RST = {BW{PWM_PERIOD_RST_FILL}};
  localparam logic [BW-1:0] D_RST = {BW{PWM_DUTY_RST_FILL}};

  // Reject dead-time settings outside the usable counter range at elaboration.
  if ((DT < 1) || (DT > (2 ** BW) - 1)) begin : g_dt_range
    $error("pwm_multi: DT must lie in 1..2^BW-1");
  end

  logic [BW-1:0]         cnt;
  pwm_dir_e              dir;
  logic [BW-1:0]         act_p;
  logic [CH-1:0][BW-1:0] act_d;
  logic                  act_m;
  logic [BW-1:0]         sh_p;
  logic [CH-1:0][BW-1:0] sh_d;
  logic                  sh_m;
  logic                  pending;
  logic                  sync_q;

  logic                  boundary;
  logic                  apply;
  logic [BW-1:0]         cnt_nxt;
  pwm_dir_e              dir_nxt;
  logic [CH-1:0]         raw;

  // A boundary is an enabled cycle whose successor restarts the count at 0.
  always_comb begin
    boundary = 1'b0;
    if (en_i) begin
      if (act_m == PWM_MODE_CENTER) begin
        // P==1 turns around at the top straight back to 0, so cnt==1 going up also ends the period.
        boundary = (act_p == '0) ||
                   ((cnt == BW'(1)) && ((dir == DIR_DOWN) || (act_p == BW'(1))));
      end else begin
        boundary = (cnt == act_p);
      end
    end
  end

  assign apply = pending && (boundary || !en_i);

  // Next counter value and direction for both alignment modes.
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (!en_i || boundary) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (act_m == PWM_MODE_EDGE) begin
      cnt_nxt = cnt + 1'b1;
    end else if (dir == DIR_UP) begin
      if (cnt == act_p) begin
        cnt_nxt = cnt - 1'b1;
        dir_nxt = DIR_DOWN;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  // Unsigned per-channel compare; D=0 never fires and D>P always fires.
  always_comb begin
    raw = '0;
    for (int k = 0; k < CH; k++) begin
      raw[k] = (cnt < act_d[k]);
    end
  end

  // Shared period counter and direction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else begin
      cnt <= cnt_nxt;
      dir <= dir_nxt;
    end
  end

  // Double buffering: boundaries consume the old shadow before a same-cycle load refills it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      act_p   <= P_RST;
      act_d   <= {CH{D_RST}};
      act_m   <= PWM_MODE_EDGE;
      sh_p    <= P_RST;
      sh_d    <= {CH{D_RST}};
      sh_m    <= PWM_MODE_EDGE;
      pending <= 1'b0;
    end else begin
      if (apply) begin
        act_p <= sh_p;
        act_d <= sh_d;
        act_m <= sh_m;
      end
      if (load_i) begin
        sh_p    <= period_i;
        sh_d    <= duty_i;
        sh_m    <= mode_i;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

  // Period-start pulse, one cycle after the enabled cnt==0 cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= en_i && (cnt == '0);
    end
  end

  assign pending_o = pending;
  assign sync_o    = sync_q;

`ifdef PWM_MULTI_DEADTIME_EN
  for (genvar k = 0; k < CH; k++) begin : g_dt
    pwm_deadtime #(
      .BW (BW),
      .DT (DT)
    ) u_deadtime (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (en_i),
      .raw_i   (raw[k]),
      .pwm_o   (pwm_o[k]),
      .pwm_n_o (pwm_n_o[k])
    );
  end
`else
  logic [CH-1:0] pwm_q;

  // Registered compare, forced low while disabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= en_i ? raw : '0;
    end
  end

  assign pwm_o = pwm_q;
`endif

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed self-checking bench for pwm_multi (BW=8, CH=4).
// A behavioural model of the counter, shadow registers and outputs pushes
// the expected output set for every clock into a scoreboard queue; the
// entry is popped and compared one time unit after the edge. Directed
// checks on sync spacing and per-channel high counts sit on top.
module tb_pwm_multi;

  localparam int BW = 8;
  localparam int CH = 4;
  localparam int DT = 2;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             en_i;
  logic             mode_i;
  logic [BW-1:0]    period_i;
  logic [CH*BW-1:0] duty_i;
  logic             load_i;
  logic             pending_o;
  logic             sync_o;
  logic [CH-1:0]    pwm_o;
`ifdef PWM_MULTI_DEADTIME_EN
  logic [CH-1:0]    pwm_n_o;
`endif

  always #5 clk_i = ~clk_i;

  pwm_multi #(
    .BW (BW),
    .CH (CH),
    .DT (DT)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .mode_i    (mode_i),
    .period_i  (period_i),
    .duty_i    (duty_i),
    .load_i    (load_i),
    .pending_o (pending_o),
    .sync_o    (sync_o),
    .pwm_o     (pwm_o)
`ifdef PWM_MULTI_DEADTIME_EN
    ,
    .pwm_n_o   (pwm_n_o)
`endif
  );

  typedef struct {
    logic [CH-1:0] pwm;
    logic [CH-1:0] pwm_n;
    logic          sync;
    logic          pending;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_fail = 0;

  // reference model state
  logic [BW-1:0] m_cnt;
  logic          m_up;
  logic [BW-1:0] m_p;
  logic [BW-1:0] m_d [CH];
  logic          m_m;
  logic [BW-1:0] s_p;
  logic [BW-1:0] s_d [CH];
  logic          s_m;
  logic          m_pend;
  int unsigned   dt_len [CH];
  logic [CH-1:0] dt_prev;

  // observation statistics
  int cyc = 0;
  int last_sync = -1;
  int sync_gaps[$];
  int hi_cnt [CH];
  int hn_cnt [CH];
  int overlap = 0;

  task automatic compareValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_cnt  = '0;
    m_up   = 1'b1;
    m_p    = 8'hFF;
    s_p    = 8'hFF;
    m_m    = 1'b0;
    s_m    = 1'b0;
    m_pend = 1'b0;
    dt_prev = '0;
    for (int k = 0; k < CH; k++) begin
      m_d[k]    = '0;
      s_d[k]    = '0;
      dt_len[k] = 0;
    end
  endtask

  // Where the count goes next if the block stays enabled.
  function automatic void modelNext(output logic [BW-1:0] nxt, output logic nxt_up);
    nxt_up = m_up;
    if (m_m == 1'b0) begin
      nxt = (m_cnt == m_p) ? '0 : m_cnt + 1'b1;
    end else if (m_p == '0) begin
      nxt = '0;
    end else if (m_up) begin
      if (m_cnt == m_p) begin
        nxt    = m_cnt - 1'b1;
        nxt_up = 1'b0;
      end else begin
        nxt = m_cnt + 1'b1;
      end
    end else begin
      nxt = m_cnt - 1'b1;
    end
  endfunction

  task automatic modelStep();
    exp_t          e;
    logic [CH-1:0] raw;
    logic [BW-1:0] nxt;
    logic          nxt_up;
    logic          bnd;
    logic          app;
    int unsigned   len;
    for (int k = 0; k < CH; k++) raw[k] = (m_cnt < m_d[k]);
    modelNext(nxt, nxt_up);
    bnd = en_i && (nxt == '0);
    app = m_pend && (bnd || !en_i);
    e.sync    = en_i && (m_cnt == '0);
    e.pending = load_i ? 1'b1 : (app ? 1'b0 : m_pend);
`ifdef PWM_MULTI_DEADTIME_EN
    for (int k = 0; k < CH; k++) begin
      if (!en_i) begin
        dt_len[k]  = 0;
        dt_prev[k] = 1'b0;
        e.pwm[k]   = 1'b0;
        e.pwm_n[k] = 1'b0;
      end else begin
        len = (raw[k] == dt_prev[k]) ? dt_len[k] + 1 : 1;
        e.pwm[k]   = raw[k] && (len > DT);
        e.pwm_n[k] = !raw[k] && (len > DT);
        dt_len[k]  = len;
        dt_prev[k] = raw[k];
      end
    end
`else
    len     = 0;
    e.pwm   = en_i ? raw : '0;
    e.pwm_n = '0;
`endif
    sb_q.push_back(e);
    if (!en_i || bnd) begin
      m_cnt = '0;
      m_up  = 1'b1;
    end else begin
      m_cnt = nxt;
      m_up  = nxt_up;
    end
    if (app) begin
      m_p = s_p;
      m_m = s_m;
      for (int k = 0; k < CH; k++) m_d[k] = s_d[k];
    end
    if (load_i) begin
      s_p = period_i;
      s_m = mode_i;
      for (int k = 0; k < CH; k++) s_d[k] = duty_i[k*BW +: BW];
    end
    m_pend = e.pending;
  endtask

  task automatic applyStimulus(input logic en, input logic load);
    en_i   = en;
    load_i = load;
    modelStep();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("[TB] FAIL %s_scoreboard: observed empty queue, required one entry", tag);
      return;
    end
    e = sb_q.pop_front();
    compareValue({tag, "_pwm"}, 32'(pwm_o), 32'(e.pwm));
    compareValue({tag, "_sync"}, 32'(sync_o), 32'(e.sync));
    compareValue({tag, "_pending"}, 32'(pending_o), 32'(e.pending));
`ifdef PWM_MULTI_DEADTIME_EN
    compareValue({tag, "_pwm_n"}, 32'(pwm_n_o), 32'(e.pwm_n));
    overlap += ((pwm_o & pwm_n_o) != '0) ? 1 : 0;
    for (int k = 0; k < CH; k++) hn_cnt[k] += int'(pwm_n_o[k]);
`endif
    for (int k = 0; k < CH; k++) hi_cnt[k] += int'(pwm_o[k]);
    if (sync_o) begin
      if (last_sync >= 0) sync_gaps.push_back(cyc - last_sync);
      last_sync = cyc;
    end
    cyc++;
  endtask

  task automatic step(input logic en, input logic load, input string tag);
    applyStimulus(en, load);
    checkOutput(tag);
  endtask

  task automatic runCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, tag);
  endtask

  // Advance until the next model cycle is a period boundary (bounded).
  task automatic seekBoundary(input string tag);
    logic [BW-1:0] nxt;
    logic          nxt_up;
    for (int i = 0; i < 600; i++) begin
      modelNext(nxt, nxt_up);
      if (nxt == '0) break;
      step(1'b1, 1'b0, tag);
    end
  endtask

  task automatic clearStats(input logic restart_gaps);
    sync_gaps.delete();
    if (restart_gaps) last_sync = -1;
    overlap = 0;
    for (int k = 0; k < CH; k++) begin
      hi_cnt[k] = 0;
      hn_cnt[k] = 0;
    end
  endtask

  function automatic int gapAt(input int i);
    return (i < sync_gaps.size()) ? sync_gaps[i] : -1;
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no completion, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i    = 1'b1;
    en_i     = 1'b0;
    load_i   = 1'b0;
    mode_i   = 1'b0;
    period_i = '0;
    duty_i   = '0;
    modelReset();
    @(posedge clk_i);
    #1;
    compareValue("reset_pwm", 32'(pwm_o), 32'd0);
    compareValue("reset_sync", 32'(sync_o), 32'd0);
    compareValue("reset_pending", 32'(pending_o), 32'd0);
    rst_i = 1'b0;

    $display("[TB] edge mode P=9 D={0,3,10,255}");
    mode_i   = 1'b0;
    period_i = 8'd9;
    duty_i   = {8'd255, 8'd10, 8'd3, 8'd0};
    step(1'b0, 1'b1, "edge_load");
    step(1'b0, 1'b0, "edge_apply_idle");
    clearStats(1'b1);
    runCycles(30, "edge_run");
    compareValue("edge_gap0", gapAt(0), 10);
    compareValue("edge_gap1", gapAt(1), 10);
`ifndef PWM_MULTI_DEADTIME_EN
    compareValue("edge_ch0_highs", hi_cnt[0], 0);
    compareValue("edge_ch1_highs", hi_cnt[1], 9);
    compareValue("edge_ch2_highs", hi_cnt[2], 30);
    compareValue("edge_ch3_highs", hi_cnt[3], 30);
`endif

    $display("[TB] shadow update P=9 -> P=19 at cnt=4");
    for (int i = 0; i < 20 && m_cnt != 8'd4; i++) step(1'b1, 1'b0, "seek_cnt4");
    period_i = 8'd19;
    clearStats(1'b0);
    step(1'b1, 1'b1, "shadow_load");
    compareValue("shadow_pending_high", 32'(pending_o), 32'd1);
    runCycles(49, "shadow_run");
    compareValue("shadow_gap0", gapAt(0), 10);
    compareValue("shadow_gap1", gapAt(1), 20);
    compareValue("shadow_gap2", gapAt(2), 20);

    $display("[TB] coincident load P=5 pending, P=7 at boundary");
    period_i = 8'd5;
    step(1'b1, 1'b1, "coinc_load5");
    seekBoundary("coinc_seek");
    period_i = 8'd7;
    clearStats(1'b0);
    step(1'b1, 1'b1, "coinc_load7");
    compareValue("coinc_pending_kept", 32'(pending_o), 32'd1);
    runCycles(20, "coinc_run");
    compareValue("coinc_gap_p5", gapAt(1), 6);
    compareValue("coinc_gap_p7", gapAt(2), 8);

    $display("[TB] center mode P=4 D1=2");
    mode_i   = 1'b1;
    period_i = 8'd4;
    duty_i   = {8'd255, 8'd10, 8'd2, 8'd0};
    step(1'b1, 1'b1, "center_load");
    seekBoundary("center_seek");
    step(1'b1, 1'b0, "center_boundary");
    clearStats(1'b1);
    runCycles(24, "center_run");
    compareValue("center_gap0", gapAt(0), 8);
    compareValue("center_gap1", gapAt(1), 8);
`ifndef PWM_MULTI_DEADTIME_EN
    compareValue("center_ch0_highs", hi_cnt[0], 0);
    compareValue("center_ch1_highs", hi_cnt[1], 9);
    compareValue("center_ch2_highs", hi_cnt[2], 24);
`endif

`ifdef PWM_MULTI_DEADTIME_EN
    $display("[TB] dead time DT=2 P=9 D0=5");
    mode_i   = 1'b0;
    period_i = 8'd9;
    duty_i   = {8'd0, 8'd0, 8'd0, 8'd5};
    step(1'b1, 1'b1, "dt_load5");
    seekBoundary("dt_seek5");
    step(1'b1, 1'b0, "dt_boundary5");
    clearStats(1'b1);
    runCycles(20, "dt_run5");
    compareValue("dt5_pwm_highs", hi_cnt[0], 6);
    compareValue("dt5_pwm_n_highs", hn_cnt[0], 6);
    compareValue("dt5_overlap", overlap, 0);
    duty_i = {8'd255, 8'd0, 8'd0, 8'd2};
    step(1'b1, 1'b1, "dt_load2");
    seekBoundary("dt_seek2");
    step(1'b1, 1'b0, "dt_boundary2");
    clearStats(1'b1);
    runCycles(20, "dt_run2");
    compareValue("dt2_pwm_highs", hi_cnt[0], 0);
    compareValue("dt2_overlap", overlap, 0);
`endif

    $display("[TB] asynchronous reset mid-period");
    period_i = 8'd3;
    runCycles(3, "pre_rst_run");
    step(1'b1, 1'b1, "pre_rst_load");
    compareValue("pre_rst_pwm3", 32'(pwm_o[3]), 32'd1);
    compareValue("pre_rst_pending", 32'(pending_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #2;
    compareValue("async_rst_pwm", 32'(pwm_o), 32'd0);
    compareValue("async_rst_pending", 32'(pending_o), 32'd0);
    compareValue("async_rst_sync", 32'(sync_o), 32'd0);
    modelReset();
    sb_q.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    clearStats(1'b1);
    step(1'b1, 1'b0, "post_rst_first");
    compareValue("post_rst_sync", 32'(sync_o), 32'd1);
    runCycles(20, "post_rst_run");
    compareValue("post_rst_highs", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
